layer_collect: RTL and testbench

- Producer-side companion to the argmax stage.
- Accepts last-layer neuron results as a serial valid/ready stream and assembles them into a NEURON_NB-entry signed buffer.
- Drives the argmax stage's sync clear and enable. Waits for its done, then latches the winning digit and reports one frame result.
- Sits between the final dense layer and the argmax/select stage.

---
 rtl/layer_collect_if.sv | 33 +++
 rtl/layer_collect.sv | 159 +++++++++++++++
 tb/tb_layer_collect.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_collect_if.sv
`default_nettype none
// ============================================================================
//  Module   : layer_collect_if
//  Brief    : Neuron-result stream plus argmax-stage bus used by layer_collect.
//  Revision : 1.0 - initial release
// ============================================================================
interface layer_collect_if #(
    parameter int NEURON_NB = 10,
    parameter int WIDTH     = 8
);
    logic                        in_valid;
    logic                        in_ready;
    logic signed [2*WIDTH-1:0]   in_data;
    logic                        in_last;

    logic signed [2*WIDTH-1:0]   sel_data [0:NEURON_NB-1];
    logic                        sel_reset;
    logic                        sel_enable;
    logic                        sel_done;
    logic        [WIDTH-1:0]     sel_digit;

    // Slave is the collector; master is whoever feeds it and hosts the argmax.
    modport slave (
        input  in_valid, in_data, in_last, sel_done, sel_digit,
        output in_ready, sel_data, sel_reset, sel_enable
    );

    modport master (
        output in_valid, in_data, in_last, sel_done, sel_digit,
        input  in_ready, sel_data, sel_reset, sel_enable
    );
endinterface
`default_nettype wire

// File: rtl/layer_collect.sv
`default_nettype none
// ============================================================================
//  Module   : layer_collect
//  Brief    : Gathers one frame of last-layer neuron results, runs the argmax
//             stage over them and reports the winning digit.
//             Optional RUN watchdog: define LAYER_COLLECT_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module layer_collect #(
    parameter int NEURON_NB = 10,
    parameter int WIDTH     = 8
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    layer_collect_if.slave        bus,
    output logic [WIDTH-1:0]      result,
    output logic                  frame_done,
    output logic                  err_short,
    output logic                  err_long
`ifdef LAYER_COLLECT_TIMEOUT_EN
    ,
    output logic                  err_timeout
`endif
);

    localparam int IDX_W = (NEURON_NB > 1) ? $clog2(NEURON_NB) : 1;
    localparam logic [IDX_W-1:0]         c_LAST_IDX = IDX_W'(NEURON_NB - 1);
    localparam logic signed [2*WIDTH-1:0] c_MOST_NEG = {1'b1, {(2*WIDTH-1){1'b0}}};

    localparam logic [1:0] c_ST_COLLECT = 2'd0;
    localparam logic [1:0] c_ST_ARM     = 2'd1;
    localparam logic [1:0] c_ST_RUN     = 2'd2;
    localparam logic [1:0] c_ST_REPORT  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_result;
    logic             r_err_short;
    logic             r_err_long;

    logic w_beat;
    logic w_at_end;
    logic w_close;
    logic w_short_fill;
    logic w_timeout;

    assign w_beat       = bus.in_valid && (r_state == c_ST_COLLECT);
    assign w_at_end     = (r_idx == c_LAST_IDX);
    assign w_close      = w_beat && (bus.in_last || w_at_end);
    assign w_short_fill = w_beat && bus.in_last && !w_at_end;

`ifdef LAYER_COLLECT_TIMEOUT_EN
    localparam int WD_W = $clog2(4 * NEURON_NB);
    localparam logic [WD_W-1:0] c_WDOG_LAST = WD_W'(4 * NEURON_NB - 1);

    logic [WD_W-1:0] r_wdog;
    logic            r_err_timeout;

    assign w_timeout = (r_state == c_ST_RUN) && (r_wdog == c_WDOG_LAST);

    // Counts cycles spent in RUN; restarts from zero every time RUN is entered.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wdog        <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_wdog <= (r_state == c_ST_RUN) ? r_wdog + 1'b1 : '0;
            if (w_timeout && !bus.sel_done)
                r_err_timeout <= 1'b1;
        end
    end

    assign err_timeout = r_err_timeout;
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n)
            r_state <= c_ST_COLLECT;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_COLLECT: if (w_close) w_next_state = c_ST_ARM;
            c_ST_ARM:     w_next_state = c_ST_RUN;
            c_ST_RUN:     if (bus.sel_done || w_timeout) w_next_state = c_ST_REPORT;
            c_ST_REPORT:  w_next_state = c_ST_COLLECT;
            default:      w_next_state = c_ST_COLLECT;
        endcase
    end

    // in_ready is gated by reset so nothing looks acceptable while reset is held.
    always_comb begin
        bus.in_ready   = reset_n && (r_state == c_ST_COLLECT);
        bus.sel_reset  = (r_state == c_ST_ARM);
        bus.sel_enable = (r_state == c_ST_RUN);
        frame_done     = (r_state == c_ST_REPORT);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_idx       <= '0;
            r_result    <= '0;
            r_err_short <= 1'b0;
            r_err_long  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_COLLECT: begin
                    if (w_close) begin
                        if (w_short_fill)
                            r_err_short <= 1'b1;
                        if (!bus.in_last)
                            r_err_long <= 1'b1;
                    end else if (w_beat) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                c_ST_RUN: begin
                    if (bus.sel_done)
                        r_result <= bus.sel_digit;
                    else if (w_timeout)
                        r_result <= '0;
                end
                c_ST_REPORT: r_idx <= '0;
                default: ;
            endcase
        end
    end

    // A short frame pads every entry after the closing beat with the most
    // negative value so padding can never win the argmax.
    for (genvar j = 0; j < NEURON_NB; j++) begin : g_buf
        localparam logic [IDX_W-1:0] c_ENTRY = IDX_W'(j);

        logic signed [2*WIDTH-1:0] r_entry;

        always_ff @(posedge clk) begin
            if (!reset_n)
                r_entry <= '0;
            else if (w_beat && (r_idx == c_ENTRY))
                r_entry <= bus.in_data;
            else if (w_short_fill && (int'(r_idx) < j))
                r_entry <= c_MOST_NEG;
        end

        assign bus.sel_data[j] = r_entry;
    end

    assign result    = r_result;
    assign err_short = r_err_short;
    assign err_long  = r_err_long;

endmodule
`default_nettype wire

// File: tb/tb_layer_collect.sv
`default_nettype none
// ============================================================================
//  Module   : tb_layer_collect
//  Brief    : Randomized self-checking bench for layer_collect with a
//             frame-level reference model and a behavioural argmax stand-in.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_layer_collect;

    localparam int N = 10;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] result;
    logic         frame_done;
    logic         err_short;
    logic         err_long;
`ifdef LAYER_COLLECT_TIMEOUT_EN
    logic         err_timeout;
`endif

    always #5 clk = ~clk;

    layer_collect_if #(.NEURON_NB(N), .WIDTH(W)) lc_bus ();

    layer_collect #(.NEURON_NB(N), .WIDTH(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (lc_bus),
        .result     (result),
        .frame_done (frame_done),
        .err_short  (err_short),
        .err_long   (err_long)
`ifdef LAYER_COLLECT_TIMEOUT_EN
        ,
        .err_timeout(err_timeout)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Highest value wins; ties go to the later index.
    function automatic int argmax_ge(input int v[N]);
        int best = 0;
        for (int i = 1; i < N; i++)
            if (v[i] >= v[best]) best = i;
        return best;
    endfunction

    // ---------------- argmax stand-in: done after N enabled cycles ----------
    int am_cnt;
    bit am_stall = 1'b0;

    function automatic int am_pick();
        int v[N];
        for (int i = 0; i < N; i++) v[i] = int'($signed(lc_bus.sel_data[i]));
        return argmax_ge(v);
    endfunction

    always @(posedge clk) begin
        if (!reset_n || lc_bus.sel_reset) begin
            am_cnt          <= 0;
            lc_bus.sel_done <= 1'b0;
        end else if (lc_bus.sel_enable && !lc_bus.sel_done && !am_stall) begin
            am_cnt <= am_cnt + 1;
            if (am_cnt == N - 1) begin
                lc_bus.sel_done  <= 1'b1;
                lc_bus.sel_digit <= W'(am_pick());
            end
        end
    end

    // ---------------- reference model / monitor ------------------------------
    int cur_vals[N];
    int cur_n = 0;
    int ref_buf[N];
    int exp_res_q[$];
    int exp_en_q[$];
    bit exp_short = 0, exp_long = 0, exp_tout = 0;
    bit close_pend = 0, run_pend = 0, in_run = 0, post_done = 0;
    int en_cnt = 0, last_res = 0;
    int n_closed = 0, n_reported = 0;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!reset_n) begin
                cur_n = 0; close_pend = 0; run_pend = 0; in_run = 0; post_done = 0;
                exp_res_q.delete(); exp_en_q.delete();
                exp_short = 0; exp_long = 0; exp_tout = 0;
                n_closed = n_reported;
            end else begin
                if (post_done) begin
                    check_eq("done_one_cycle", int'(frame_done), 0);
                    check_eq("ready_after_report", int'(lc_bus.in_ready), 1);
                    check_eq("result_hold", int'(result), last_res);
                    post_done = 0;
                end
                if (frame_done) begin
                    if (exp_res_q.size() == 0) begin
                        check_eq("unexpected_frame_done", 1, 0);
                    end else begin
                        last_res = exp_res_q.pop_front();
                        check_eq("run_cycles", en_cnt, exp_en_q.pop_front());
                        check_eq("result", int'(result), last_res);
                        check_eq("err_short", int'(err_short), int'(exp_short));
                        check_eq("err_long", int'(err_long), int'(exp_long));
`ifdef LAYER_COLLECT_TIMEOUT_EN
                        check_eq("err_timeout", int'(err_timeout), int'(exp_tout));
`endif
                        check_eq("ready_in_report", int'(lc_bus.in_ready), 0);
                        check_eq("enable_in_report", int'(lc_bus.sel_enable), 0);
                    end
                    post_done = 1; in_run = 0; n_reported++;
                end
                if (in_run && lc_bus.sel_enable) en_cnt++;
                if (run_pend) begin
                    check_eq("enable_start", int'(lc_bus.sel_enable), 1);
                    check_eq("sel_reset_one_cycle", int'(lc_bus.sel_reset), 0);
                    check_eq("ready_in_run", int'(lc_bus.in_ready), 0);
                    for (int k = 0; k < N; k++)
                        check_eq($sformatf("sel_data[%0d]", k),
                                 int'($signed(lc_bus.sel_data[k])), ref_buf[k]);
                    run_pend = 0; in_run = 1; en_cnt = 1;
                end
                if (close_pend) begin
                    check_eq("sel_reset", int'(lc_bus.sel_reset), 1);
                    check_eq("ready_in_arm", int'(lc_bus.in_ready), 0);
                    close_pend = 0; run_pend = 1;
                end
                if (lc_bus.in_valid && lc_bus.in_ready) begin
                    cur_vals[cur_n] = int'($signed(lc_bus.in_data));
                    cur_n++;
                    if (lc_bus.in_last || cur_n == N) begin
                        for (int k = 0; k < N; k++)
                            ref_buf[k] = (k < cur_n) ? cur_vals[k] : -32768;
                        if (cur_n < N) exp_short = 1;
                        if (cur_n == N && !lc_bus.in_last) exp_long = 1;
                        if (am_stall) exp_tout = 1;
                        exp_res_q.push_back(am_stall ? 0 : argmax_ge(ref_buf));
                        exp_en_q.push_back(am_stall ? 4 * N : N + 1);
                        cur_n = 0; close_pend = 1; n_closed++;
                    end
                end
            end
        end
    end

    // ---------------- stimulus -----------------------------------------------
    int tx_vals[N];

    task automatic send_frame(input int n, input bit last_final, input int gap_pct,
                              input bit hold);
        int waitc;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(99) < gap_pct) begin
                lc_bus.in_valid = 1'b0; lc_bus.in_last = 1'b0;
                @(negedge clk);
            end
            lc_bus.in_valid = 1'b1;
            lc_bus.in_data  = 16'(tx_vals[i]);
            lc_bus.in_last  = (i == n - 1) && last_final;
            waitc = 0;
            while (!lc_bus.in_ready && waitc < 200) begin
                @(negedge clk);
                waitc++;
            end
            if (waitc >= 200) begin
                check_eq("ready_wait_timeout", 0, 1);
                lc_bus.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        if (!hold) begin
            lc_bus.in_valid = 1'b0; lc_bus.in_last = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int c = 0;
        while ((n_reported != n_closed || !lc_bus.in_ready) && c < 600) begin
            @(negedge clk);
            c++;
        end
        if (c >= 600) check_eq("idle_timeout", 0, 1);
    endtask

    task automatic rand_vals();
        for (int i = 0; i < N; i++)
            tx_vals[i] = ($urandom_range(3) == 0) ? int'($urandom_range(8)) - 4
                                                  : int'($urandom_range(65535)) - 32768;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int n;
        reset_n = 1'b0;
        lc_bus.in_valid = 1'b0; lc_bus.in_last = 1'b0; lc_bus.in_data = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_in_ready", int'(lc_bus.in_ready), 0);
        check_eq("rst_result", int'(result), 0);
        check_eq("rst_frame_done", int'(frame_done), 0);
        check_eq("rst_sel_reset", int'(lc_bus.sel_reset), 0);
        check_eq("rst_sel_enable", int'(lc_bus.sel_enable), 0);
        check_eq("rst_errs", int'({err_short, err_long}), 0);
        check_eq("rst_buf", int'(lc_bus.sel_data[N-1]), 0);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("ready_after_reset", int'(lc_bus.in_ready), 1);

        // Directed frame: tie at 40 resolves to the later index.
        tx_vals = '{5, -3, 40, 7, 0, 12, 40, -1, 2, 9};
        send_frame(N, 1'b1, 0, 1'b0);
        wait_idle();
        check_eq("f1_result", int'(result), 6);
        check_eq("f1_no_err", int'({err_short, err_long}), 0);

        // Short frame padded with most-negative entries.
        tx_vals = '{1, 2, 100, 3, 0, 0, 0, 0, 0, 0};
        send_frame(4, 1'b1, 0, 1'b0);
        wait_idle();
        check_eq("f2_result", int'(result), 2);
        check_eq("f2_err_short", int'(err_short), 1);
        check_eq("f2_pad", int'($signed(lc_bus.sel_data[9])), -32768);

        // Long frame: no in_last on the tenth beat.
        rand_vals();
        send_frame(N, 1'b0, 25, 1'b0);
        wait_idle();
        check_eq("f3_err_long", int'(err_long), 1);

        // Back-to-back frames with in_valid held high throughout.
        rand_vals();
        send_frame(N, 1'b1, 0, 1'b1);
        rand_vals();
        send_frame(7, 1'b1, 0, 1'b0);
        wait_idle();

        // Reset mid-frame discards the partial frame and all sticky state.
        rand_vals();
        send_frame(6, 1'b0, 0, 1'b0);
        reset_n = 1'b0;
        @(negedge clk);
        check_eq("abort_frame_done", int'(frame_done), 0);
        check_eq("abort_result", int'(result), 0);
        check_eq("abort_errs", int'({err_short, err_long}), 0);
        check_eq("abort_buf", int'(lc_bus.sel_data[0]), 0);
        check_eq("abort_in_ready", int'(lc_bus.in_ready), 0);
        reset_n = 1'b1;
        @(negedge clk);
        rand_vals();
        send_frame(N, 1'b1, 20, 1'b0);
        wait_idle();

        for (int f = 0; f < 20; f++) begin
            rand_vals();
            n = $urandom_range(1, N);
            send_frame(n, (n < N) ? 1'b1 : 1'($urandom_range(1)), 30, 1'($urandom_range(1)));
        end
        lc_bus.in_valid = 1'b0; lc_bus.in_last = 1'b0;
        wait_idle();

`ifdef LAYER_COLLECT_TIMEOUT_EN
        am_stall = 1'b1;
        rand_vals();
        send_frame(N, 1'b1, 0, 1'b0);
        wait_idle();
        check_eq("timeout_result", int'(result), 0);
        check_eq("timeout_flag", int'(err_timeout), 1);
        am_stall = 1'b0;
        rand_vals();
        send_frame(5, 1'b1, 0, 1'b0);
        wait_idle();
`endif

        repeat (3) @(negedge clk);
        check_eq("all_frames_reported", n_reported, n_closed);
        check_eq("no_pending_expect", exp_res_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
